// File: rtl/flag_branch_unit_pkg.sv
// Shared encodings for the flag/branch unit: condition codes, flag-write controls, run state.
package flag_branch_unit_pkg;

  localparam int OFF_W = 9;

  localparam logic [2:0] CC_NEQ    = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GTE    = 3'b100;
  localparam logic [2:0] CC_LTE    = 3'b101;
  localparam logic [2:0] CC_OVFL   = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  localparam logic [1:0] FLAG_NONE = 2'b00;
  localparam logic [1:0] FLAG_Z    = 2'b01;
  localparam logic [1:0] FLAG_ZNV  = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
  } flags_t;

endpackage

// File: rtl/flag_branch_unit_if.sv
// Control/flag inputs and PC/flag outputs of the flag/branch unit; master drives, slave is the unit.
interface flag_branch_unit_if #(
  parameter int PC_W = 16
);
  logic            alu_zr;
  logic            alu_n;
  logic            alu_ov;
  logic [1:0]      flag_upd;
  logic            br_valid;
  logic [2:0]      br_ccc;
  logic [8:0]      br_offset;
  logic            jmp_valid;
  logic [PC_W-1:0] jmp_target;
  logic            hlt;
  logic            stall;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus1;
  logic            flag_z;
  logic            flag_n;
  logic            flag_v;
  logic            br_taken;
  logic            halted;

  modport master (
    output alu_zr, alu_n, alu_ov, flag_upd, br_valid, br_ccc, br_offset,
           jmp_valid, jmp_target, hlt, stall,
    input  pc, pc_plus1, flag_z, flag_n, flag_v, br_taken, halted
  );

  modport slave (
    input  alu_zr, alu_n, alu_ov, flag_upd, br_valid, br_ccc, br_offset,
           jmp_valid, jmp_target, hlt, stall,
    output pc, pc_plus1, flag_z, flag_n, flag_v, br_taken, halted
  );
endinterface

// File: rtl/flag_branch_unit_cond_eval.sv
// Combinational branch condition evaluation against architectural Z/N/V; zero latency.
module cond_eval
  import flag_branch_unit_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic       z,
  input  logic       n,
  input  logic       v,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (ccc)
      CC_NEQ:    cond_true = ~z;
      CC_EQ:     cond_true = z;
      CC_GT:     cond_true = ~z & ~n;
      CC_LT:     cond_true = n;
      CC_GTE:    cond_true = z | ~n;
      CC_LTE:    cond_true = z | n;
      CC_OVFL:   cond_true = v;
      CC_UNCOND: cond_true = 1'b1;
      default:   cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// PC, Z/N/V flag and RUN/HALTED owner; pc/flags/halted update one edge after the decision,
// br_taken and pc_plus1 are combinational. stall freezes all state; HALTED is left only by reset.
module flag_branch_unit
  import flag_branch_unit_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  flag_branch_unit_if.slave  bus
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_plus1;
  logic [PC_W-1:0] br_off_sext;
  flags_t          flags_q, flags_d;
  state_e          state_q, state_d;
  logic            run;
  logic            cond_true;
  logic            br_taken;

  cond_eval u_cond_eval (
    .ccc       (bus.br_ccc),
    .z         (flags_q.z),
    .n         (flags_q.n),
    .v         (flags_q.v),
    .cond_true (cond_true)
  );

  assign run         = (state_q == ST_RUN);
  assign pc_plus1    = pc_q + PC_W'(1);
  assign br_off_sext = {{(PC_W-OFF_W){bus.br_offset[OFF_W-1]}}, bus.br_offset};
  assign br_taken    = bus.br_valid & cond_true & run & rst_n;

  always_comb begin
    pc_d    = pc_q;
    flags_d = flags_q;
    state_d = state_q;
    if (run && !bus.stall) begin
      case (bus.flag_upd)
        FLAG_Z:   flags_d.z = bus.alu_zr;
        FLAG_ZNV: flags_d   = '{z: bus.alu_zr, n: bus.alu_n, v: bus.alu_ov};
        default:  flags_d   = flags_q;
      endcase
      // hlt outranks jump and branch; the PC stays on the HLT instruction.
      if (bus.hlt)            state_d = ST_HALT;
      else if (bus.jmp_valid) pc_d    = bus.jmp_target;
      else if (br_taken)      pc_d    = pc_plus1 + br_off_sext;
      else                    pc_d    = pc_plus1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      flags_q <= '0;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      flags_q <= flags_d;
      state_q <= state_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus1 = pc_plus1;
  assign bus.flag_z   = flags_q.z;
  assign bus.flag_n   = flags_q.n;
  assign bus.flag_v   = flags_q.v;
  assign bus.br_taken = br_taken;
  assign bus.halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed vectors with hand-computed expectations, checked by a queue-fed monitor.
module tb_flag_branch_unit;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  flag_branch_unit_if #(.PC_W(16)) bus ();

  flag_branch_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          idx;
    logic        tk;
    logic [15:0] pc_now;
    logic [15:0] pc_nxt;
    logic [2:0]  znv;
    logic        hl;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_vec = 0;
  int n_err = 0;
  int vec_idx = 0;

  task automatic check(input int idx, input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL vec %0d %s: got %h, expected %h", idx, name, act, exp);
    end
  endtask

  task automatic apply(input logic rn, input logic [1:0] fu, input logic zr, input logic nn,
                       input logic ov, input logic bv, input logic [2:0] ccc, input logic [8:0] off,
                       input logic jv, input logic [15:0] jt, input logic h, input logic st,
                       input logic e_tk, input logic [15:0] e_now, input logic [15:0] e_nxt,
                       input logic [2:0] e_znv, input logic e_hl);
    sb_item_t it;
    @(negedge clk);
    rst_n          = rn;
    bus.flag_upd   = fu;
    bus.alu_zr     = zr;
    bus.alu_n      = nn;
    bus.alu_ov     = ov;
    bus.br_valid   = bv;
    bus.br_ccc     = ccc;
    bus.br_offset  = off;
    bus.jmp_valid  = jv;
    bus.jmp_target = jt;
    bus.hlt        = h;
    bus.stall      = st;
    vec_idx++;
    it = '{idx: vec_idx, tk: e_tk, pc_now: e_now, pc_nxt: e_nxt, znv: e_znv, hl: e_hl};
    sb_q.push_back(it);
  endtask

  task automatic idle(input logic [15:0] e_now, input logic [15:0] e_nxt, input logic [2:0] e_znv);
    apply(1, 2'b00, 0, 0, 0, 0, 3'b000, 9'h000, 0, 16'h0000, 0, 0, 0, e_now, e_nxt, e_znv, 0);
  endtask

  // Monitor: combinational outputs before the edge, registered state just after it.
  initial begin
    sb_item_t it;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() != 0) begin
        it = sb_q.pop_front();
        check(it.idx, "br_taken", 16'(bus.br_taken), 16'(it.tk));
        check(it.idx, "pc_now", bus.pc, it.pc_now);
        check(it.idx, "pc_plus1", bus.pc_plus1, it.pc_now + 16'd1);
        @(posedge clk);
        #1;
        check(it.idx, "pc_next", bus.pc, it.pc_nxt);
        check(it.idx, "flags_znv", 16'({bus.flag_z, bus.flag_n, bus.flag_v}), 16'(it.znv));
        check(it.idx, "halted", 16'(bus.halted), 16'(it.hl));
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    bus.flag_upd = 2'b00; bus.alu_zr = 0; bus.alu_n = 0; bus.alu_ov = 0;
    bus.br_valid = 0; bus.br_ccc = 3'b000; bus.br_offset = 9'h000;
    bus.jmp_valid = 0; bus.jmp_target = 16'h0000; bus.hlt = 0; bus.stall = 0;
    #1 rst_n = 1'b0;

    // rst  fu     zr n ov bv ccc     off     jv jt        h st  tk now      next     znv     hl
    apply(0, 2'b00, 0, 0, 0, 0, 3'b000, 9'h000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 3'b000, 0);
    idle(16'h0000, 16'h0001, 3'b000);
    idle(16'h0001, 16'h0002, 3'b000);
    idle(16'h0002, 16'h0003, 3'b000);
    idle(16'h0003, 16'h0004, 3'b000);
    apply(1, 2'b10, 0, 1, 1, 0, 3'b000, 9'h000, 0, 16'h0000, 0, 0, 0, 16'h0004, 16'h0005, 3'b011, 0);
    apply(1, 2'b00, 0, 0, 0, 1, 3'b011, 9'h1F0, 0, 16'h0000, 0, 0, 1, 16'h0005, 16'hFFF6, 3'b011, 0);
    apply(1, 2'b01, 1, 0, 0, 0, 3'b000, 9'h000, 0, 16'h0000, 0, 0, 0, 16'hFFF6, 16'hFFF7, 3'b111, 0);
    apply(1, 2'b00, 0, 0, 0, 1, 3'b001, 9'h002, 0, 16'h0000, 0, 0, 1, 16'hFFF7, 16'hFFFA, 3'b111, 0);
    apply(1, 2'b00, 0, 0, 0, 1, 3'b010, 9'h002, 0, 16'h0000, 0, 0, 0, 16'hFFFA, 16'hFFFB, 3'b111, 0);
    apply(1, 2'b00, 0, 0, 0, 1, 3'b110, 9'h1FF, 0, 16'h0000, 0, 0, 1, 16'hFFFB, 16'hFFFB, 3'b111, 0);
    apply(1, 2'b00, 0, 0, 0, 1, 3'b000, 9'h010, 0, 16'h0000, 0, 0, 0, 16'hFFFB, 16'hFFFC, 3'b111, 0);
    apply(1, 2'b00, 0, 0, 0, 1, 3'b100, 9'h003, 0, 16'h0000, 0, 0, 1, 16'hFFFC, 16'h0000, 3'b111, 0);
    apply(1, 2'b10, 0, 0, 0, 0, 3'b000, 9'h000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0001, 3'b000, 0);
    apply(1, 2'b01, 1, 0, 0, 1, 3'b001, 9'h004, 0, 16'h0000, 0, 0, 0, 16'h0001, 16'h0002, 3'b100, 0);
    apply(1, 2'b00, 0, 0, 0, 1, 3'b111, 9'h005, 1, 16'hFFFF, 0, 0, 1, 16'h0002, 16'hFFFF, 3'b100, 0);
    idle(16'hFFFF, 16'h0000, 3'b100);
    apply(1, 2'b00, 0, 0, 0, 0, 3'b000, 9'h000, 1, 16'h0010, 0, 0, 0, 16'h0000, 16'h0010, 3'b100, 0);
    apply(1, 2'b10, 0, 1, 1, 1, 3'b111, 9'h005, 1, 16'h1234, 1, 1, 1, 16'h0010, 16'h0010, 3'b100, 0);
    apply(1, 2'b10, 0, 1, 1, 1, 3'b111, 9'h005, 1, 16'h1234, 1, 0, 1, 16'h0010, 16'h0010, 3'b011, 1);
    for (int i = 0; i < 5; i++)
      apply(1, 2'b10, 1, 0, 0, 1, 3'b111, 9'h005, 1, 16'h1234, 0, 0, 0, 16'h0010, 16'h0010, 3'b011, 1);
    apply(0, 2'b10, 1, 0, 0, 1, 3'b111, 9'h005, 1, 16'h1234, 0, 0, 0, 16'h0000, 16'h0000, 3'b000, 0);
    idle(16'h0000, 16'h0001, 3'b000);

    @(negedge clk);
    @(negedge clk);
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected responses left unchecked, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
